// File: rtl/data_mem_pkg.sv
// Shared state encoding and default parameter values for the clearable data memory.
package data_mem_pkg;

    localparam int unsigned DEFAULT_DW   = 8;
    localparam int unsigned DEFAULT_AW   = 8;
    localparam int unsigned DEFAULT_FILL = 0;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/clear_sequencer.sv
// Clear-sweep controller: walks every address once, then idles until the next clear request.
module clear_sequencer
    import data_mem_pkg::*;
#(
    parameter int unsigned AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          busy,
    output logic [AW-1:0] sweep_addr,
    output logic          done
);

    localparam int unsigned DEPTH = 2 ** AW;
    // One spare bit keeps the terminal compare independent of counter wrap.
    localparam logic [AW:0] LAST  = (AW + 1)'(DEPTH - 1);

    state_e      state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            SWEEP: begin
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + (AW + 1)'(1);
                end
            end
            READY: begin
                if (clear) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy       = (state_q == SWEEP);
    assign sweep_addr = cnt_q[AW-1:0];
    assign done       = done_q;

endmodule

// File: rtl/param_data_mem.sv
// Dual-read, single-write data memory with a self-timed clear sweep after reset or on request.
module param_data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned     DW   = DEFAULT_DW,
    parameter int unsigned     AW   = DEFAULT_AW,
    parameter logic [DW-1:0]   FILL = DW'(DEFAULT_FILL)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          MemWriteEn,
    input  logic [AW-1:0] WrAddress,
    input  logic [DW-1:0] DataIn,
    input  logic [AW-1:0] RdAddrA,
    input  logic [AW-1:0] RdAddrB,
    input  logic          Clear,
    output logic [DW-1:0] DataOutA,
    output logic [DW-1:0] DataOutB,
    output logic          Busy,
    output logic          ClearDone,
    output logic          WrDropped
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic          busy;
    logic [AW-1:0] sweep_addr;
    logic          wr_drop_q, wr_drop_d;
    logic          wr_en_c;
    logic [AW-1:0] wr_addr_c;
    logic [DW-1:0] wr_data_c;

    clear_sequencer #(
        .AW (AW)
    ) u_clear_sequencer (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .clear      (Clear),
        .busy       (busy),
        .sweep_addr (sweep_addr),
        .done       (ClearDone)
    );

    // Sweep owns the write port; a user write is only taken in READY without a clear.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = WrAddress;
        wr_data_c = DataIn;
        wr_drop_d = 1'b0;
        if (busy) begin
            wr_en_c   = 1'b1;
            wr_addr_c = sweep_addr;
            wr_data_c = FILL;
            wr_drop_d = MemWriteEn;
        end else if (Clear) begin
            wr_drop_d = MemWriteEn;
        end else begin
            wr_en_c = MemWriteEn;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en_c) begin
            mem_q[wr_addr_c] <= wr_data_c;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    assign DataOutA  = busy ? FILL : mem_q[RdAddrA];
    assign DataOutB  = busy ? FILL : mem_q[RdAddrB];
    assign Busy      = busy;
    assign WrDropped = wr_drop_q;

endmodule

// File: tb/tb_param_data_mem.sv
// Directed self-checking bench for param_data_mem at DW=8, AW=4, FILL=8'hA5.
module tb_param_data_mem;

    localparam logic [7:0] FILLV = 8'hA5;

    logic       Clk;
    logic       Reset_n;
    logic       MemWriteEn;
    logic [3:0] WrAddress;
    logic [7:0] DataIn;
    logic [3:0] RdAddrA;
    logic [3:0] RdAddrB;
    logic       Clear;
    logic [7:0] DataOutA;
    logic [7:0] DataOutB;
    logic       Busy;
    logic       ClearDone;
    logic       WrDropped;

    int pass_cnt  = 0;
    int total_cnt = 0;

    param_data_mem #(
        .DW   (8),
        .AW   (4),
        .FILL (8'hA5)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .MemWriteEn (MemWriteEn),
        .WrAddress  (WrAddress),
        .DataIn     (DataIn),
        .RdAddrA    (RdAddrA),
        .RdAddrB    (RdAddrB),
        .Clear      (Clear),
        .DataOutA   (DataOutA),
        .DataOutB   (DataOutB),
        .Busy       (Busy),
        .ClearDone  (ClearDone),
        .WrDropped  (WrDropped)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b1; MemWriteEn = 1'b0; WrAddress = '0; DataIn = '0;
        RdAddrA = '0; RdAddrB = '0; Clear = 1'b0;
        #1 Reset_n = 1'b0;
        tick(); tick();
        total_cnt++;
        if (Busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", Busy); else pass_cnt++;
        total_cnt++;
        if (ClearDone !== 1'b0) $display("FAIL reset_done: got %b expected 0", ClearDone); else pass_cnt++;
        total_cnt++;
        if (WrDropped !== 1'b0) $display("FAIL reset_drop: got %b expected 0", WrDropped); else pass_cnt++;
        Reset_n = 1'b1;
    endtask

    task automatic test_power_up_sweep();
        int fall_k = 0;
        int done_k = 0;
        int dones  = 0;
        RdAddrA = 4'd3;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!Busy && fall_k == 0) fall_k = k;
            if (ClearDone) begin dones++; if (done_k == 0) done_k = k; end
            if (k == 5) begin
                total_cnt++;
                if (DataOutA !== FILLV) $display("FAIL sweep_forced_fill: got %h expected %h", DataOutA, FILLV);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (fall_k != 16) $display("FAIL powerup_busy_len: got %0d expected 16", fall_k); else pass_cnt++;
        total_cnt++;
        if (done_k != 16) $display("FAIL powerup_done_cycle: got %0d expected 16", done_k); else pass_cnt++;
        total_cnt++;
        if (dones != 1) $display("FAIL powerup_done_count: got %0d expected 1", dones); else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            RdAddrA = 4'(a);
            #1;
            total_cnt++;
            if (DataOutA !== FILLV) $display("FAIL powerup_fill[%0d]: got %h expected %h", a, DataOutA, FILLV);
            else pass_cnt++;
        end
    endtask

    task automatic test_read_during_write();
        RdAddrA = 4'd5; RdAddrB = 4'd5;
        MemWriteEn = 1'b1; WrAddress = 4'd5; DataIn = 8'h3C;
        #1;
        total_cnt++;
        if (DataOutA !== FILLV) $display("FAIL rdw_old_a: got %h expected %h", DataOutA, FILLV); else pass_cnt++;
        total_cnt++;
        if (DataOutB !== FILLV) $display("FAIL rdw_old_b: got %h expected %h", DataOutB, FILLV); else pass_cnt++;
        tick();
        MemWriteEn = 1'b0;
        #1;
        total_cnt++;
        if (DataOutA !== 8'h3C) $display("FAIL rdw_new_a: got %h expected 3c", DataOutA); else pass_cnt++;
        total_cnt++;
        if (DataOutB !== 8'h3C) $display("FAIL rdw_new_b: got %h expected 3c", DataOutB); else pass_cnt++;
        total_cnt++;
        if (WrDropped !== 1'b0) $display("FAIL rdw_no_drop: got %b expected 0", WrDropped); else pass_cnt++;
        // Top address, with port B on a different word.
        MemWriteEn = 1'b1; WrAddress = 4'd15; DataIn = 8'h11;
        tick();
        MemWriteEn = 1'b0; RdAddrA = 4'd15; RdAddrB = 4'd0;
        #1;
        total_cnt++;
        if (DataOutA !== 8'h11) $display("FAIL top_addr_a: got %h expected 11", DataOutA); else pass_cnt++;
        total_cnt++;
        if (DataOutB !== FILLV) $display("FAIL other_addr_b: got %h expected %h", DataOutB, FILLV); else pass_cnt++;
    endtask

    task automatic test_drop_during_sweep();
        int done_k = 0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        total_cnt++;
        if (Busy !== 1'b1) $display("FAIL clear_enters_sweep: got %b expected 1", Busy); else pass_cnt++;
        repeat (3) tick();
        MemWriteEn = 1'b1; WrAddress = 4'd2; DataIn = 8'h77;
        tick();
        MemWriteEn = 1'b0;
        total_cnt++;
        if (WrDropped !== 1'b1) $display("FAIL sweep_drop_pulse: got %b expected 1", WrDropped); else pass_cnt++;
        for (int k = 5; k <= 30; k++) begin
            tick();
            if (k == 5) begin
                total_cnt++;
                if (WrDropped !== 1'b0) $display("FAIL sweep_drop_single: got %b expected 0", WrDropped);
                else pass_cnt++;
            end
            if (ClearDone && done_k == 0) done_k = k;
        end
        total_cnt++;
        if (done_k != 16) $display("FAIL clear_done_cycle: got %0d expected 16", done_k); else pass_cnt++;
        RdAddrA = 4'd2; RdAddrB = 4'd5;
        #1;
        total_cnt++;
        if (DataOutA !== FILLV) $display("FAIL dropped_not_written: got %h expected %h", DataOutA, FILLV); else pass_cnt++;
        total_cnt++;
        if (DataOutB !== FILLV) $display("FAIL sweep_cleared_word: got %h expected %h", DataOutB, FILLV); else pass_cnt++;
    endtask

    task automatic test_clear_with_write();
        int fall_k = 0;
        Clear = 1'b1; MemWriteEn = 1'b1; WrAddress = 4'd7; DataIn = 8'h99;
        tick();
        Clear = 1'b0; MemWriteEn = 1'b0;
        total_cnt++;
        if (WrDropped !== 1'b1) $display("FAIL clear_write_drop: got %b expected 1", WrDropped); else pass_cnt++;
        total_cnt++;
        if (Busy !== 1'b1) $display("FAIL clear_write_busy: got %b expected 1", Busy); else pass_cnt++;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (!Busy && fall_k == 0) fall_k = k;
        end
        total_cnt++;
        if (fall_k != 16) $display("FAIL clear_write_sweep_len: got %0d expected 16", fall_k); else pass_cnt++;
        RdAddrA = 4'd7; RdAddrB = 4'd7;
        #1;
        total_cnt++;
        if (DataOutA !== FILLV) $display("FAIL clear_write_not_stored: got %h expected %h", DataOutA, FILLV); else pass_cnt++;
        total_cnt++;
        if (DataOutB !== DataOutA || DataOutB !== FILLV)
            $display("FAIL same_addr_ports: got %h expected %h", DataOutB, FILLV);
        else pass_cnt++;
    endtask

    task automatic test_clear_ignored();
        int done_k = 0;
        int dones  = 0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        repeat (8) tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        total_cnt++;
        if (Busy !== 1'b1) $display("FAIL ignored_clear_busy: got %b expected 1", Busy); else pass_cnt++;
        for (int k = 10; k <= 40; k++) begin
            tick();
            if (ClearDone) begin dones++; if (done_k == 0) done_k = k; end
        end
        total_cnt++;
        if (done_k != 16) $display("FAIL ignored_clear_done_cycle: got %0d expected 16", done_k); else pass_cnt++;
        total_cnt++;
        if (dones != 1) $display("FAIL ignored_clear_done_count: got %0d expected 1", dones); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        int fall_k = 0;
        int done_k = 0;
        MemWriteEn = 1'b1; WrAddress = 4'd9; DataIn = 8'h42;
        tick();
        MemWriteEn = 1'b0; RdAddrA = 4'd9;
        #1;
        total_cnt++;
        if (DataOutA !== 8'h42) $display("FAIL pre_reset_write: got %h expected 42", DataOutA); else pass_cnt++;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        repeat (8) tick();
        MemWriteEn = 1'b1;
        tick();
        MemWriteEn = 1'b0;
        Reset_n = 1'b0;
        #1;
        total_cnt++;
        if (Busy !== 1'b1) $display("FAIL midreset_busy: got %b expected 1", Busy); else pass_cnt++;
        total_cnt++;
        if (ClearDone !== 1'b0) $display("FAIL midreset_done: got %b expected 0", ClearDone); else pass_cnt++;
        total_cnt++;
        if (WrDropped !== 1'b0) $display("FAIL midreset_drop_cleared: got %b expected 0", WrDropped); else pass_cnt++;
        tick(); tick();
        Reset_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (!Busy && fall_k == 0) fall_k = k;
            if (ClearDone && done_k == 0) done_k = k;
        end
        total_cnt++;
        if (fall_k != 16) $display("FAIL midreset_sweep_len: got %0d expected 16", fall_k); else pass_cnt++;
        total_cnt++;
        if (done_k != 16) $display("FAIL midreset_done_cycle: got %0d expected 16", done_k); else pass_cnt++;
        #1;
        total_cnt++;
        if (DataOutA !== FILLV) $display("FAIL midreset_refilled: got %h expected %h", DataOutA, FILLV); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_power_up_sweep();
        test_read_during_write();
        test_drop_during_sweep();
        test_clear_with_write();
        test_clear_ignored();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/param_data_mem.md
PARAM_DATA_MEM -- requirements
Module: param_data_mem

Interface
REQ-001 The module SHALL expose parameter DW, default 8, meaning data width in bits.
REQ-002 The module SHALL expose parameter AW, default 8, meaning address width; depth DEPTH = 2**AW.
REQ-003 The module SHALL expose parameter FILL, default 0, meaning the DW-bit value written by every clear sweep.
REQ-004 The port list SHALL be as follows; one clock; reset is asynchronous and active-low:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- MemWriteEn  in  1  write request
- WrAddress  in  AW  write address
- DataIn  in  DW  write data
- RdAddrA  in  AW  read port A address
- RdAddrB  in  AW  read port B address
- Clear  in  1  single-cycle clear-sweep request
- DataOutA  out  DW  read port A data
- DataOutB  out  DW  read port B data
- Busy  out  1  clear sweep in progress
- ClearDone  out  1  one-cycle pulse when a sweep completes
- WrDropped  out  1  one-cycle pulse when a write was discarded

Function
REQ-005 Storage SHALL be DEPTH words of DW bits; reads are combinational, writes occur on the rising edge of Clk.
REQ-006 The controller SHALL have two states: SWEEP (Busy=1) and READY (Busy=0).
REQ-007 In SWEEP, a counter SHALL write FILL to one address per cycle, ascending from 0 to DEPTH-1.
REQ-008 The edge that writes address DEPTH-1 SHALL move the state to READY, so that Busy falls and ClearDone is 1 for exactly the following cycle.
REQ-009 A sweep SHALL take exactly DEPTH cycles from its first write to READY.
REQ-010 In READY, Clear=1 SHALL enter SWEEP at the next edge with the counter at 0.
REQ-011 In READY, a write SHALL not occur in the same cycle as Clear=1.
REQ-012 Clear asserted during SWEEP SHALL be ignored: no restart and no extension.
REQ-013 In READY with Clear=0, MemWriteEn=1 SHALL write DataIn to WrAddress at the edge.
REQ-014 MemWriteEn=1 while Busy=1, or coincident with an accepted Clear, SHALL discard the write.
REQ-015 Each discarded write SHALL produce WrDropped=1 for the cycle after the discarding edge.
REQ-016 While Busy=1, DataOutA and DataOutB SHALL both equal FILL, regardless of the array contents.
REQ-017 In READY, DataOutA SHALL equal the word at RdAddrA and DataOutB the word at RdAddrB.
REQ-018 Read-during-write to the same address SHALL return the old word until the write edge and the new word afterwards.
REQ-019 Both read ports addressing the same location SHALL return identical data.
REQ-020 The sweep counter SHALL be AW+1 bits wide so that terminal detection does not depend on wrap-around.

Reset
REQ-021 Reset_n=0 SHALL asynchronously force state SWEEP with the counter at 0, Busy=1, ClearDone=0 and WrDropped=0.
REQ-022 Reset SHALL not asynchronously clear the array; contents become FILL through the sweep that starts at the first edge after Reset_n rises.
REQ-023 Reset asserted mid-sweep or mid-write SHALL abandon the operation, and the full sweep SHALL restart from address 0 after release.

Structure
REQ-024 Package data_mem_pkg SHALL hold the state enum (SWEEP, READY) and the default parameter constants.
REQ-025 The state register and sweep counter SHALL live in sub-module clear_sequencer, which outputs busy, sweep address and done.
REQ-026 The array and the read/write muxing SHALL live in param_data_mem; no other sub-modules SHALL be used.

Verification (DW=8, AW=4, DEPTH=16, FILL=8'hA5)
REQ-027 Release Reset_n, hold all inputs 0 -> Busy=1 for 16 cycles, ClearDone pulses once, then DataOutA=8'hA5 at every address.
REQ-028 In READY, write 8'h3C to address 5 with RdAddrA=5 and RdAddrB=5 -> both outputs read 8'hA5 before the edge and 8'h3C after it.
REQ-029 Pulse Clear, then assert MemWriteEn at sweep cycle 3 with address 2 and data 8'h77 -> WrDropped pulses, and address 2 reads 8'hA5 after ClearDone.
REQ-030 Assert Clear and MemWriteEn in the same READY cycle -> write dropped, WrDropped=1, and a sweep of 16 cycles begins.
REQ-031 Pulse Clear again at sweep cycle 8 -> ignored; ClearDone appears exactly 16 cycles after the original Clear.
REQ-032 Assert Reset_n=0 at sweep cycle 10 -> Busy=1 and ClearDone=0 immediately; after release, the sweep takes 16 full cycles.
